// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue: opcodes, NOP encoding, reset PC.
// Also holds the immediate decoders used by the optional static predictor.
package instr_prefetch_queue_pkg;

    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_static_bpred.sv
// Static predictor: JAL always taken, conditional branches taken when backward.
// Only built when PREFETCH_BPRED_EN is defined.
`ifdef PREFETCH_BPRED_EN
module static_bpred
    import instr_prefetch_queue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        taken,
    output logic [31:0] target
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        taken  = 1'b0;
        target = pc + 32'd4;
        if (instr[6:0] == OPC_JAL) begin
            taken  = 1'b1;
            target = pc + imm_j(instr);
        end else if (instr[6:0] == OPC_BRANCH && instr[31]) begin
            taken  = 1'b1;
            target = pc + imm_b(instr);
        end
    end

endmodule
`endif

// File: rtl/instr_prefetch_queue.sv
// Fetch PC owner and in-order instruction queue feeding Decode (FWFT head).
// Define PREFETCH_BPRED_EN to enable early redirect on backward branches and JAL.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_imem_req,
    input  logic        i_imem_gnt,
    input  logic        i_imem_vld,
    input  logic [31:0] i_instr,
    input  logic        i_boj,
    input  logic [31:0] i_boj_pc,
    input  logic        i_trap,
    input  logic [31:0] i_trap_pc,
    input  logic        i_stall,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_prediction
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   out_t;
    localparam cnt_t DEPTH_C   = cnt_t'(DEPTH);
    localparam out_t OUT_DEPTH = out_t'(DEPTH);

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_next, pred_q;
    ptr_t             head_q, tail_q, fill_q;
    cnt_t             count_q, inflight_q, drop_q, fill_span;
    out_t             outstanding;
    logic [31:0]      iaddr_q, redirect_pc, pred_target;
    logic             redirect, issue, pop, resp_any, resp_drop, resp_fill;
    logic             pred_taken, pred_fire;

    assign redirect    = i_trap | i_boj;
    assign redirect_pc = i_trap ? i_trap_pc : i_boj_pc;
    assign outstanding = {1'b0, inflight_q} + {1'b0, drop_q};
    assign resp_any    = i_imem_vld && (outstanding != '0);
    assign resp_drop   = i_imem_vld && (drop_q != '0);
    assign resp_fill   = i_imem_vld && (drop_q == '0) && (inflight_q != '0);
    assign pred_fire   = resp_fill && pred_taken && !redirect;
    // Entries head..fill inclusive survive a prediction; everything younger is released.
    assign fill_span   = {1'b0, ptr_t'(fill_q - head_q)} + cnt_t'(1);

`ifdef PREFETCH_BPRED_EN
    static_bpred u_static_bpred (
        .instr  (i_instr),
        .pc     (pc_q[fill_q]),
        .taken  (pred_taken),
        .target (pred_target)
    );
`else
    assign pred_taken  = 1'b0;
    assign pred_target = '0;
`endif

    assign o_imem_req   = rst_n && !redirect && (count_q < DEPTH_C) && (outstanding < OUT_DEPTH);
    assign issue        = o_imem_req && i_imem_gnt;
    assign o_iaddr      = iaddr_q;
    assign o_valid      = filled_q[head_q];
    assign pop          = o_valid && !i_stall && !redirect;
    assign o_instr      = o_valid ? instr_q[head_q] : INSTR_NOP;
    assign o_pc         = o_valid ? pc_q[head_q] : '0;
    assign o_prediction = o_valid && pred_q[head_q];

    always_comb begin
        filled_next = filled_q;
        if (resp_fill) filled_next[fill_q] = 1'b1;
        if (pop)       filled_next[head_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            filled_q   <= '0;
            iaddr_q    <= RESET_PC;
        end else if (redirect) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= cnt_t'(outstanding - out_t'(resp_any));
            filled_q   <= '0;
            iaddr_q    <= redirect_pc;
        end else begin
            filled_q <= filled_next;
            if (pop)       head_q <= head_q + ptr_t'(1);
            if (resp_fill) fill_q <= fill_q + ptr_t'(1);
            if (pred_fire) begin
                // A request granted this cycle is on the wrong path too, so it joins the drop count.
                tail_q     <= fill_q + ptr_t'(1);
                count_q    <= fill_span - cnt_t'(pop);
                inflight_q <= '0;
                drop_q     <= inflight_q - cnt_t'(1) + cnt_t'(issue);
                iaddr_q    <= pred_target;
            end else begin
                if (issue) begin
                    tail_q  <= tail_q + ptr_t'(1);
                    iaddr_q <= iaddr_q + 32'd4;
                end
                count_q    <= count_q + cnt_t'(issue) - cnt_t'(pop);
                inflight_q <= inflight_q + cnt_t'(issue) - cnt_t'(resp_fill);
                if (resp_drop) drop_q <= drop_q - cnt_t'(1);
            end
        end
    end

    // NOTE: payload storage has no reset; nothing is visible until its filled flag is set.
    always_ff @(posedge clk) begin
        if (issue) pc_q[tail_q] <= iaddr_q;
        if (resp_fill) begin
            instr_q[fill_q] <= i_instr;
            pred_q[fill_q]  <= pred_fire;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: in-order memory model plus a PC-stream scoreboard.
// Honours PREFETCH_BPRED_EN for the expected stream after a backward branch.
module tb_instr_prefetch_queue;
    import instr_prefetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] BR_INSTR = 32'hFE00_0CE3; // beq x0,x0,-8
    localparam logic [31:0] NO_BR    = 32'hFFFF_FF00;
`ifdef PREFETCH_BPRED_EN
    localparam logic [31:0] AFTER_BR = 32'h0000_0008;
`else
    localparam logic [31:0] AFTER_BR = 32'h0000_0014;
`endif

    logic        clk, rst_n;
    logic [31:0] o_iaddr, i_instr, i_boj_pc, i_trap_pc, o_instr, o_pc;
    logic        o_imem_req, i_imem_gnt, i_imem_vld, i_boj, i_trap, i_stall, o_valid, o_prediction;

    instr_prefetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .o_iaddr(o_iaddr), .o_imem_req(o_imem_req),
        .i_imem_gnt(i_imem_gnt), .i_imem_vld(i_imem_vld), .i_instr(i_instr),
        .i_boj(i_boj), .i_boj_pc(i_boj_pc), .i_trap(i_trap), .i_trap_pc(i_trap_pc),
        .i_stall(i_stall), .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
        .o_prediction(o_prediction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct { logic [31:0] addr; int unsigned ready; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic pred; } exp_t;
    typedef struct { logic trap; logic [31:0] trap_pc; logic boj; logic [31:0] boj_pc; logic [31:0] exp_pc; } redir_vec_t;

    mreq_t       pend[$];
    exp_t        sb[$];
    int unsigned cyc = 0, last_ready = 0;
    int          gnt_pct = 100, lat_lo = 1, lat_hi = 1, pops = 0;
    logic        mem_resp = 1'b0, after_br_checked = 1'b1;
    logic [31:0] branch_addr = NO_BR, model_pc = RST_PC, prev_pop_pc = '1, hold_exp;
    logic        s_req, s_valid, s_pred;
    logic [31:0] s_iaddr, s_pc, s_instr;

    function automatic logic [31:0] instr_at(input logic [31:0] addr);
        if (addr == branch_addr) return BR_INSTR;
        return {addr[24:0], 7'b0010011};
    endfunction

    function automatic logic pred_at(input logic [31:0] pc);
`ifdef PREFETCH_BPRED_EN
        return pc == branch_addr;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
`ifdef PREFETCH_BPRED_EN
        if (pc == branch_addr) return pc - 32'd8;
`endif
        return pc + 32'd4;
    endfunction

    task automatic sb_top_up();
        while (sb.size() < 2) begin
            sb.push_back('{pc: model_pc, instr: instr_at(model_pc), pred: pred_at(model_pc)});
            model_pc = next_pc(model_pc);
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        sb.delete();
        model_pc    = pc;
        prev_pop_pc = '1;
        sb_top_up();
    endtask

    // Called at the falling edge: pick this cycle's grant and in-order response.
    task automatic drive_mem();
        i_imem_gnt = ($urandom_range(99) < gnt_pct);
        mem_resp   = (pend.size() != 0) && (pend[0].ready <= cyc);
        i_imem_vld = mem_resp;
        i_instr    = mem_resp ? instr_at(pend[0].addr) : $urandom;
    endtask

    task automatic tick();
        logic        fire, redir, pop;
        logic [31:0] tgt;
        int unsigned r;
        exp_t        e;
        #1;
        s_req = o_imem_req; s_iaddr = o_iaddr; s_valid = o_valid;
        s_pc  = o_pc;       s_instr = o_instr; s_pred  = o_prediction;
        fire  = o_imem_req && i_imem_gnt;
        redir = rst_n && (i_boj || i_trap);
        tgt   = i_trap ? i_trap_pc : i_boj_pc;
        pop   = rst_n && o_valid && !i_stall && !redir;
        if (pop) begin
            sb_top_up();
            e = sb.pop_front();
            check("pop_pc", o_pc, e.pc);
            check("pop_instr", o_instr, e.instr);
            check("pop_pred", 32'(o_prediction), 32'(e.pred));
            if (!after_br_checked && prev_pop_pc == branch_addr) begin
                check("after_branch_pc", o_pc, AFTER_BR);
                after_br_checked = 1'b1;
            end
            prev_pop_pc = o_pc;
            pops++;
        end
        @(posedge clk);
        if (fire) begin
            r = cyc + $urandom_range(lat_hi, lat_lo);
            if (r < last_ready) r = last_ready;
            last_ready = r;
            pend.push_back('{addr: s_iaddr, ready: r});
        end
        if (mem_resp) void'(pend.pop_front());
        if (!rst_n)     sb_restart(RST_PC);
        else if (redir) sb_restart(tgt);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},   32'(s_req),   32'd0);
        check({tag, "_valid"}, 32'(s_valid), 32'd0);
        check({tag, "_instr"}, s_instr,      INSTR_NOP);
        check({tag, "_pc"},    s_pc,         32'd0);
        check({tag, "_pred"},  32'(s_pred),  32'd0);
        check({tag, "_iaddr"}, s_iaddr,      RST_PC);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!s_valid && k < budget) begin
            drive_mem(); tick(); k++;
        end
    endtask

    redir_vec_t rv[3];

    initial begin
        rv[0] = '{trap: 1'b0, trap_pc: 32'h0,   boj: 1'b1, boj_pc: 32'h100, exp_pc: 32'h100};
        rv[1] = '{trap: 1'b1, trap_pc: 32'h80,  boj: 1'b1, boj_pc: 32'h200, exp_pc: 32'h80};
        rv[2] = '{trap: 1'b1, trap_pc: 32'h340, boj: 1'b0, boj_pc: 32'h0,   exp_pc: 32'h340};

        rst_n = 1'b0; i_stall = 1'b0; i_boj = 1'b0; i_trap = 1'b0;
        i_boj_pc = '0; i_trap_pc = '0; i_imem_gnt = 1'b0; i_imem_vld = 1'b0; i_instr = '0;
        @(negedge clk);
        repeat (2) begin drive_mem(); tick(); end
        check_reset("reset");

        // Sequential fetch, always-grant, 1-cycle memory.
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive_mem(); tick();
            check("seq_iaddr", s_iaddr, RST_PC + 32'(4 * c));
            check("seq_valid", 32'(s_valid), 32'(c >= 2));
            if (c == 2) check("seq_first_pc", s_pc, RST_PC);
        end

        // Decode stall: queue fills, requests stop, head holds.
        sb_top_up();
        hold_exp = sb[0].pc;
        i_stall  = 1'b1;
        repeat (10) begin drive_mem(); tick(); end
        check("stall_head_pc", s_pc, hold_exp);
        check("stall_req", 32'(s_req), 32'd0);
        check("stall_valid", 32'(s_valid), 32'd1);
        drive_mem();
        if (pend.size() == 0) begin i_imem_vld = 1'b1; i_instr = 32'hDEAD_BEEF; end
        tick();
        i_stall = 1'b0;
        repeat (12) begin drive_mem(); tick(); end

        // Redirects with several requests in flight.
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 3; i++) begin
            repeat (8) begin drive_mem(); tick(); end
            drive_mem();
            i_trap = rv[i].trap; i_trap_pc = rv[i].trap_pc;
            i_boj  = rv[i].boj;  i_boj_pc  = rv[i].boj_pc;
            tick();
            i_trap = 1'b0; i_boj = 1'b0;
            drive_mem(); tick();
            check("redir_valid", 32'(s_valid), 32'd0);
            check("redir_iaddr", s_iaddr, rv[i].exp_pc);
            check("redir_req", 32'(s_req), 32'd1);
            wait_valid(12);
            check("redir_first_valid", 32'(s_valid), 32'd1);
            check("redir_first_pc", s_pc, rv[i].exp_pc);
        end

        // Backward branch at 0x10.
        lat_lo = 1; lat_hi = 1;
        branch_addr = 32'h10;
        after_br_checked = 1'b0;
        drive_mem(); i_trap = 1'b1; i_trap_pc = 32'h0; tick();
        i_trap = 1'b0;
        repeat (30) begin drive_mem(); tick(); end
        check("branch_reached", 32'(after_br_checked), 32'd1);
        after_br_checked = 1'b1;

        // Random grant, latency, stall and redirects; 1000 instructions.
        gnt_pct = 70; lat_lo = 1; lat_hi = 4; pops = 0;
        for (int c = 0; c < 20000 && pops < 1000; c++) begin
            drive_mem();
            i_stall   = ($urandom_range(99) < 20);
            i_boj     = ($urandom_range(99) < 2);
            i_boj_pc  = 32'($urandom_range(1023)) << 2;
            i_trap    = ($urandom_range(99) < 1);
            i_trap_pc = 32'($urandom_range(1023)) << 2;
            tick();
        end
        i_stall = 1'b0; i_boj = 1'b0; i_trap = 1'b0;
        check("random_pop_count", 32'(pops), 32'd1000);

        // Reset in the middle of traffic; late responses must be ignored.
        rst_n = 1'b0;
        repeat (12) begin drive_mem(); tick(); end
        check_reset("midreset");
        rst_n = 1'b1;
        wait_valid(40);
        check("post_reset_valid", 32'(s_valid), 32'd1);
        check("post_reset_pc", s_pc, RST_PC);
        repeat (10) begin drive_mem(); tick(); end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
